// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and helpers for the NTT output reorder slice.
// Holds the per-bank state encoding, the default ring modulus and the
// bit-reversal helper used to place bit-reversed input words.
package ntt_pkg;

    localparam int DEFAULT_MODULUS = 7681;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Reverse the low 'width' bits of idx; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = idx[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_pingpong_ram.sv
// ntt_pingpong_ram: two banks of 2**AW words, one write port and one
// synchronous read port. The read register only updates when rd_en is high,
// so a stalled consumer sees the last read word held.
module ntt_pingpong_ram
    import ntt_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int DEPTH = 2 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;
    logic [W-1:0] rd_data_d;

    // Write port: bank select is the address MSB.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Read port next value: fetch on rd_en, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[{rd_bank, rd_addr}];
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder: turns bit-reversed NTT output frames of RADIX words into
// a natural-order ready/valid stream through a ping-pong buffer.
// Optional build macro NTT_REORDER_CANON_EN: subtract MODULUS from words that
// are >= MODULUS before they reach the output register.
// Read pipeline: issue (address) -> RAM read register -> output register.
// The issue side tracks its own bank pointer so the next frame's reads start
// right after the previous frame's last read, with no bubble; the drain-side
// pointer (rd_bank) frees a bank only when its out_last word is accepted.
module ntt_bitrev_reorder
    import ntt_pkg::*;
#(
    parameter  int W       = 32,
    parameter  int RADIX   = 16,
    parameter  int MODULUS = DEFAULT_MODULUS,
    localparam int AW      = $clog2(RADIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          overflow,
    output logic [15:0]   frame_cnt
);

`ifdef NTT_REORDER_CANON_EN
    localparam bit CANON_EN = 1'b1;
`else
    localparam bit CANON_EN = 1'b0;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(RADIX - 1);
    localparam logic [W-1:0]  MOD_W    = W'(MODULUS);

    // Fold a lazily reduced value from [0, 2*MODULUS) into [0, MODULUS).
    function automatic logic [W-1:0] canon(input logic [W-1:0] w);
        return (CANON_EN && (w >= MOD_W)) ? (w - MOD_W) : w;
    endfunction

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic          wr_bank_q,  wr_bank_d;
    logic [AW-1:0] wr_cnt_q,   wr_cnt_d;
    logic          rd_bank_q,  rd_bank_d;
    logic          iss_bank_q, iss_bank_d;
    logic [AW-1:0] iss_cnt_q,  iss_cnt_d;
    logic          stg_vld_q,  stg_vld_d;
    logic [AW-1:0] stg_idx_q,  stg_idx_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [AW-1:0] out_index_q, out_index_d;
    logic          out_last_q,  out_last_d;
    logic          overflow_q,  overflow_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          wr_ok;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          advance;
    logic          iss_ok;
    logic          rd_en;
    logic          last_fire;
    logic [W-1:0]  rd_data;

    ntt_pingpong_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_bank (iss_bank_q),
        .rd_addr (iss_cnt_q),
        .rd_data (rd_data)
    );

    // Next-state logic for bank states, pointers, read pipeline and status.
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        iss_bank_d  = iss_bank_q;
        iss_cnt_d   = iss_cnt_q;
        stg_vld_d   = stg_vld_q;
        stg_idx_d   = stg_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;

        // Write side: ready follows the registered state of the write bank.
        wr_ok   = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
        wr_en   = in_valid && wr_ok;
        wr_addr = AW'(bitrev(32'(wr_cnt_q), AW));

        // Whole read pipeline moves only when the output register can take a word.
        advance   = !out_valid_q || out_ready;
        iss_ok    = (state_q[iss_bank_q] == FULL) ||
                    ((state_q[iss_bank_q] == DRAINING) && (iss_cnt_q != '0));
        rd_en     = advance && iss_ok;
        last_fire = out_valid_q && out_ready && out_last_q;

        if (in_valid && !wr_ok) begin
            overflow_d = 1'b1;
        end

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (state_q[wr_bank_q] == EMPTY) begin
                state_d[wr_bank_q] = FILLING;
            end
            if (wr_cnt_q == LAST_IDX) begin
                state_d[wr_bank_q] = FULL;
                wr_bank_d          = ~wr_bank_q;
            end
        end

        if (rd_en) begin
            iss_cnt_d = iss_cnt_q + 1'b1;
            if (state_q[iss_bank_q] == FULL) begin
                state_d[iss_bank_q] = DRAINING;
            end
            if (iss_cnt_q == LAST_IDX) begin
                iss_bank_d = ~iss_bank_q;
            end
        end

        if (advance) begin
            stg_vld_d   = rd_en;
            stg_idx_d   = iss_cnt_q;
            out_valid_d = stg_vld_q;
            if (stg_vld_q) begin
                out_data_d  = canon(rd_data);
                out_index_d = stg_idx_q;
                out_last_d  = (stg_idx_q == LAST_IDX);
            end
        end

        if (last_fire) begin
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = ~rd_bank_q;
            frame_cnt_d        = frame_cnt_q + 16'd1;
        end
    end

    // State and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            iss_bank_q  <= 1'b0;
            iss_cnt_q   <= '0;
            stg_vld_q   <= 1'b0;
            stg_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            iss_bank_q  <= iss_bank_d;
            iss_cnt_q   <= iss_cnt_d;
            stg_vld_q   <= stg_vld_d;
            stg_idx_q   <= stg_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = wr_ok;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// tb_ntt_bitrev_reorder: directed scoreboard bench for ntt_bitrev_reorder.
// Honours NTT_REORDER_CANON_EN when computing expected output words.
module tb_ntt_bitrev_reorder;

    localparam int W     = 32;
    localparam int RADIX = 16;
    localparam int AW    = 4;
    localparam int MOD   = 7681;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          overflow;
    logic [15:0]   frame_cnt;

    ntt_bitrev_reorder #(
        .W       (W),
        .RADIX   (RADIX),
        .MODULUS (MOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          first_cyc = 0;
    bit          want_first = 1'b0;
    logic [31:0] frm [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] brev(input logic [3:0] n);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = n[3-i];
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef NTT_REORDER_CANON_EN
        return (w >= 32'(MOD)) ? (w - 32'(MOD)) : w;
`else
        return w;
`endif
    endfunction

    // Output monitor: scoreboard pops on accepted words, stall stability checks.
    initial begin
        bit          stalled;
        logic [31:0] h_data;
        logic [3:0]  h_idx;
        logic        h_last;
        exp_t        e;
        stalled = 1'b0;
        h_data = '0;
        h_idx = '0;
        h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, h_data);
                chk("hold_index", 32'(out_index), 32'(h_idx));
                chk("hold_last", 32'(out_last), 32'(h_last));
            end
            stalled = 1'b0;
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (want_first) begin
                    first_cyc  = cyc;
                    want_first = 1'b0;
                end
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_index", 32'(out_index), 32'(e.idx));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end
            if (out_valid && !out_ready) begin
                stalled = 1'b1;
                h_data  = out_data;
                h_idx   = out_index;
                h_last  = out_last;
            end
        end
    end

    // Hard stop so the bench can never hang.
    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int n = 0; n < RADIX; n++) begin
            e.data = exp_word(frm[brev(4'(n))]);
            e.idx  = 4'(n);
            e.last = (n == RADIX - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic send_frame(input bit gate, input bit toggle);
        push_frame();
        for (int p = 0; p < RADIX; p++) begin
            if (gate) wait_in_ready();
            if (toggle) out_ready = ~out_ready;
            send_word(frm[p]);
        end
    endtask

    task automatic wait_drain(input bit toggle);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            if (toggle) out_ready = ~out_ready;
            step();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rst       = 1'b0;
        step();
        step();
        sb.delete();
        rst = 1'b1;
        step();
    endtask

    // Directed test sequence.
    initial begin
        int acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        do_reset();

        // Reset values
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single frame 0..15, first output latency
        for (int p = 0; p < RADIX; p++) frm[p] = 32'(p);
        want_first = 1'b1;
        send_frame(1'b0, 1'b0);
        acc = cyc;
        wait_drain(1'b0);
        chk("latency", 32'(first_cyc - acc), 32'd2);
        chk("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // Three frames back to back
        do_reset();
        max_run = 0;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < RADIX; p++) frm[p] = 32'(1000 + 16 * f + p);
            send_frame(1'b1, 1'b0);
        end
        wait_drain(1'b0);
        chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
        chk("overflow_b2b", 32'(overflow), 32'd0);
        chk("no_bubble_2frames", 32'(max_run >= 32), 32'd1);

        // Sink stalled: two frames fill both banks, 33rd word is dropped
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < RADIX; p++) frm[p] = 32'(200 + p);
        send_frame(1'b0, 1'b0);
        for (int p = 0; p < RADIX; p++) frm[p] = 32'(300 + p);
        send_frame(1'b0, 1'b0);
        chk("in_ready_full", 32'(in_ready), 32'd0);
        chk("overflow_before", 32'(overflow), 32'd0);
        send_word(32'd999);
        chk("overflow_set", 32'(overflow), 32'd1);
        repeat (4) step();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        wait_drain(1'b0);
        repeat (4) step();
        chk("frame_cnt_stall", 32'(frame_cnt), 32'd2);

        // out_ready toggling every cycle during the drain
        do_reset();
        for (int p = 0; p < RADIX; p++) frm[p] = 32'(50 + 3 * p);
        send_frame(1'b0, 1'b1);
        wait_drain(1'b1);
        chk("frame_cnt_toggle", 32'(frame_cnt), 32'd1);

        // Reset in the middle of a frame
        do_reset();
        for (int p = 0; p < 7; p++) send_word(32'(500 + p));
        rst = 1'b0;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b1;
        step();
        for (int p = 0; p < RADIX; p++) frm[p] = 32'(100 + p);
        send_frame(1'b0, 1'b0);
        wait_drain(1'b0);
        repeat (4) step();
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("midrst_overflow", 32'(overflow), 32'd0);

        // Values at and above the modulus
        do_reset();
        for (int p = 0; p < RADIX; p++) frm[p] = 32'(p);
        frm[0] = 32'd7690;
        frm[1] = 32'd7680;
        frm[2] = 32'd7681;
        send_frame(1'b0, 1'b0);
        wait_drain(1'b0);
        chk("frame_cnt_canon", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
